// File: rtl/obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter with an in-order owner FIFO that routes each
// rvalid/rdata beat back to the master that issued the transaction.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         master_req_i  [NUM_REQ],
  output obi_resp_t        master_resp_o [NUM_REQ],
  output obi_req_t         slave_req_o,
  input  obi_resp_t        slave_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             rsp_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic             cand_valid;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head;
  logic             fifo_full;
  logic             handshake;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!cand_valid && master_req_i[i].req && (i >= int'(rr_ptr))) begin
        cand_valid = 1'b1;
        cand       = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!cand_valid && master_req_i[i].req) begin
        cand_valid = 1'b1;
        cand       = IDX_W'(i);
      end
    end
  end

  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
  assign head      = fifo_q[rd_ptr];
  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & (count != '0);

  // Held in reset the arbiter forwards nothing, so no handshake can be lost.
  always_comb begin
    slave_req_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_valid && (cand == IDX_W'(i))) begin
        slave_req_o = master_req_i[i];
      end
    end
    slave_req_o.req = cand_valid & ~fifo_full & rst_ni;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      master_resp_o[i].gnt    = handshake & (cand == IDX_W'(i));
      master_resp_o[i].rvalid = pop & (head == IDX_W'(i));
      master_resp_o[i].rdata  = rst_ni ? slave_resp_i.rdata : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_q[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (handshake) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({handshake, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (slave_resp_i.rvalid && (count == '0)) begin
        rsp_err_o <= 1'b1;
      end
    end
  end

  assign outstanding_o = count;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: a cycle vector table followed by
// scoreboard-driven sequences against a small slave model.

module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NREQ = 3;
  localparam int MAXO = 2;

  logic      clk = 1'b0;
  logic      rst_n;
  obi_req_t  mreq  [NREQ];
  obi_resp_t mresp [NREQ];
  obi_req_t  sreq;
  obi_resp_t sresp;
  logic [1:0] outstanding;
  logic      rsp_err;

  always #5 clk = ~clk;

  obi_rr_arbiter #(.NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .master_req_i (mreq),
    .master_resp_o(mresp),
    .slave_req_o  (sreq),
    .slave_resp_i (sresp),
    .outstanding_o(outstanding),
    .rsp_err_o    (rsp_err)
  );

  typedef struct {
    logic [2:0]  req;
    logic        sgnt;
    logic        srv;
    logic [31:0] srdata;
    logic        exp_sreq;
    logic [31:0] exp_addr;
    logic [2:0]  exp_gnt;
    logic [2:0]  exp_rv;
    logic [1:0]  exp_cnt;
  } vec_t;

  typedef struct { int m; logic [31:0] data; } sb_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  vec_t  vecs [11];
  sb_t   sb [$];
  pend_t pend [$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   model_rr, model_cnt, peak, exp_hs, slv_hs, slave_lat;
  logic model_err;
  logic slave_gnt;
  int   left [NREQ];
  int   seq  [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] gntVec();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = mresp[i].gnt;
    return v;
  endfunction

  function automatic logic [NREQ-1:0] rvVec();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = mresp[i].rvalid;
    return v;
  endfunction

  task automatic modelReset();
    model_rr  = 0;
    model_cnt = 0;
    model_err = 1'b0;
    sb.delete();
  endtask

  task automatic startSeq();
    exp_hs = 0;
    slv_hs = 0;
    peak   = 0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0;
      seq[i]  = 0;
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    sresp = '0;
    for (int i = 0; i < NREQ; i++) mreq[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    pend.delete();
  endtask

  // Masters present their current transaction; the slave returns queued beats when due.
  task automatic applyStimulus();
    pend_t p;
    for (int i = 0; i < NREQ; i++) begin
      mreq[i].req   = (left[i] > 0);
      mreq[i].we    = 1'b0;
      mreq[i].be    = 4'hF;
      mreq[i].addr  = 32'(seq[i] * 256 + i * 16);
      mreq[i].wdata = ~mreq[i].addr;
    end
    sresp.gnt = slave_gnt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      sresp.rvalid = 1'b1;
      sresp.rdata  = p.data;
    end else begin
      sresp.rvalid = 1'b0;
      sresp.rdata  = 32'h5A5A5A5A;
    end
  endtask

  task automatic checkOutput();
    int c;
    logic any, allow, hs_exp, pop_exp;
    logic [NREQ-1:0] eg, er;
    sb_t e;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (model_rr + k) % NREQ;
      if (!any && left[idx] > 0) begin
        any = 1'b1;
        c   = idx;
      end
    end
    allow  = any && (model_cnt < MAXO);
    hs_exp = allow && sresp.gnt;
    eg = '0;
    if (hs_exp) eg[c] = 1'b1;
    check("sreq_req", 32'(sreq.req), 32'(allow));
    if (any) check("sreq_addr", sreq.addr, 32'(seq[c] * 256 + c * 16));
    check("gnt", 32'(gntVec()), 32'(eg));
    check("outstanding", 32'(outstanding), 32'(model_cnt));
    check("rsp_err", 32'(rsp_err), 32'(model_err));
    pop_exp = sresp.rvalid && (model_cnt > 0);
    er = '0;
    if (pop_exp) begin
      e = sb.pop_front();
      er[e.m] = 1'b1;
      check("rdata", mresp[e.m].rdata, e.data);
    end else if (sresp.rvalid) begin
      model_err = 1'b1;
    end
    check("rvalid", 32'(rvVec()), 32'(er));
    if (hs_exp) begin
      exp_hs++;
      sb.push_back('{c, {16'hCAFE, 16'(exp_hs)}});
      model_rr = (c + 1) % NREQ;
    end
    model_cnt = model_cnt + (hs_exp ? 1 : 0) - (pop_exp ? 1 : 0);
    if (sreq.req && sresp.gnt) begin
      slv_hs++;
      pend.push_back('{cyc + slave_lat, {16'hCAFE, 16'(slv_hs)}});
    end
    for (int i = 0; i < NREQ; i++) begin
      if (mresp[i].gnt && left[i] > 0) begin
        left[i]--;
        seq[i]++;
      end
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [NREQ-1:0] order [8];
    int n, grants, first_rv, third_gnt;

    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   3'b000, 3'b000, 2'd0};
    vecs[1]  = '{3'b110, 1'b1, 1'b0, 32'h0,  1'b1, 32'h110, 3'b010, 3'b000, 2'd0};
    vecs[2]  = '{3'b111, 1'b1, 1'b1, 32'hA1, 1'b1, 32'h120, 3'b100, 3'b010, 2'd1};
    vecs[3]  = '{3'b111, 1'b1, 1'b0, 32'h0,  1'b1, 32'h100, 3'b001, 3'b000, 2'd1};
    vecs[4]  = '{3'b111, 1'b1, 1'b1, 32'hA2, 1'b0, 32'h110, 3'b000, 3'b100, 2'd2};
    vecs[5]  = '{3'b010, 1'b0, 1'b0, 32'h0,  1'b1, 32'h110, 3'b000, 3'b000, 2'd1};
    vecs[6]  = '{3'b010, 1'b1, 1'b1, 32'hA3, 1'b1, 32'h110, 3'b010, 3'b001, 2'd1};
    vecs[7]  = '{3'b001, 1'b1, 1'b0, 32'h0,  1'b1, 32'h100, 3'b001, 3'b000, 2'd1};
    vecs[8]  = '{3'b000, 1'b0, 1'b1, 32'hA4, 1'b0, 32'h0,   3'b000, 3'b010, 2'd2};
    vecs[9]  = '{3'b000, 1'b0, 1'b1, 32'hA5, 1'b0, 32'h0,   3'b000, 3'b001, 2'd1};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   3'b000, 3'b000, 2'd0};

    rst_n = 1'b0;
    sresp = '0;
    for (int i = 0; i < NREQ; i++) mreq[i] = '0;
    slave_gnt = 1'b0;
    slave_lat = 1;
    startSeq();
    modelReset();

    // Reset values, including a requester and a granting slave held in reset.
    @(posedge clk);
    #1;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_sreq_idle", 32'(sreq.req) | sreq.addr, 32'd0);
    mreq[0].req  = 1'b1;
    sresp.gnt    = 1'b1;
    sresp.rdata  = 32'hFFFFFFFF;
    #1;
    check("rst_gnt", 32'(gntVec()), 32'd0);
    check("rst_rdata", mresp[0].rdata, 32'd0);
    resetDut();

    for (int r = 0; r < 11; r++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        mreq[i].req   = vecs[r].req[i];
        mreq[i].we    = 1'b0;
        mreq[i].be    = 4'hF;
        mreq[i].addr  = 32'(256 + i * 16);
        mreq[i].wdata = 32'(i);
      end
      sresp.gnt    = vecs[r].sgnt;
      sresp.rvalid = vecs[r].srv;
      sresp.rdata  = vecs[r].srdata;
      @(negedge clk);
      check($sformatf("vec%0d_sreq", r), 32'(sreq.req), 32'(vecs[r].exp_sreq));
      check($sformatf("vec%0d_addr", r), sreq.addr, vecs[r].exp_addr);
      check($sformatf("vec%0d_gnt", r), 32'(gntVec()), 32'(vecs[r].exp_gnt));
      check($sformatf("vec%0d_rvalid", r), 32'(rvVec()), 32'(vecs[r].exp_rv));
      check($sformatf("vec%0d_cnt", r), 32'(outstanding), 32'(vecs[r].exp_cnt));
      check($sformatf("vec%0d_rdata", r), mresp[2].rdata, vecs[r].srdata);
    end
    resetDut();

    $display("[TB] single master");
    startSeq();
    slave_lat = 1;
    left[1]   = 1;
    slave_gnt = 1'b0;
    cycle();
    cycle();
    slave_gnt = 1'b1;
    cycle();
    check("single_gnt_c3", 32'(gntVec()), 32'b010);
    cycle();
    check("single_rvalid", 32'(mresp[1].rvalid), 32'd1);
    check("single_rdata", mresp[1].rdata, 32'hCAFE0001);
    cycle();
    check("single_cnt_end", 32'(outstanding), 32'd0);

    $display("[TB] fairness");
    startSeq();
    slave_lat = 1;
    slave_gnt = 1'b1;
    left[0] = 4;
    left[1] = 4;
    n = 0;
    for (int k = 0; k < 8; k++) order[k] = '0;
    repeat (11) begin
      cycle();
      if (gntVec() != '0 && n < 8) begin
        order[n] = gntVec();
        n++;
      end
    end
    for (int k = 0; k < 8; k++)
      check($sformatf("fair_order%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'b001 : 32'b010);

    $display("[TB] full stall");
    startSeq();
    slave_lat = 5;
    slave_gnt = 1'b1;
    left[0]   = 3;
    grants    = 0;
    first_rv  = -1;
    third_gnt = -1;
    repeat (16) begin
      cycle();
      if (sresp.rvalid && first_rv < 0) first_rv = cyc;
      if (mresp[0].gnt) begin
        grants++;
        if (grants == 3) third_gnt = cyc;
      end
    end
    check("stall_third_after_rv", 32'(third_gnt), 32'(first_rv + 1));
    check("stall_peak_le_max", 32'(peak <= MAXO), 32'd1);
    check("stall_peak", 32'(peak), 32'd2);

    $display("[TB] push/pop");
    startSeq();
    slave_lat = 1;
    slave_gnt = 1'b1;
    left[1]   = 1;
    cycle();
    left[0] = 1;
    cycle();
    check("pp_gnt0", 32'(mresp[0].gnt), 32'd1);
    check("pp_rv1", 32'(mresp[1].rvalid), 32'd1);
    cycle();
    check("pp_cnt_held", 32'(outstanding), 32'd1);
    check("pp_rv0", 32'(mresp[0].rvalid), 32'd1);
    cycle();

    $display("[TB] spurious response");
    startSeq();
    pend.push_back('{cyc + 1, 32'hDEAD0001});
    cycle();
    check("spur_no_rv", 32'(rvVec()), 32'd0);
    cycle();
    check("spur_err", 32'(rsp_err), 32'd1);

    $display("[TB] reset mid-burst");
    startSeq();
    slave_lat = 5;
    slave_gnt = 1'b1;
    left[0] = 1;
    left[1] = 1;
    cycle();
    cycle();
    cycle();
    check("mid_cnt_before", 32'(outstanding), 32'd2);
    #2;
    rst_n = 1'b0;
    sresp = '0;
    #1;
    check("mid_cnt_async", 32'(outstanding), 32'd0);
    check("mid_rr_async", 32'(dut.rr_ptr), 32'd0);
    check("mid_err_async", 32'(rsp_err), 32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle();
    check("mid_stale_err", 32'(rsp_err), 32'd1);
    left[0] = 1;
    left[2] = 1;
    cycle();
    check("mid_first_gnt", 32'(gntVec()), 32'b001);
    repeat (12) cycle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
